// File: rtl/snake_engine.sv
// snake_engine: grid snake segment store with tick-driven movement, growth,
// reversal blocking, self-collision detection and a registered pixel hit query.
module snake_engine #(
    parameter int MAX_LEN   = 16,
    parameter int INIT_LEN  = 3,
    parameter int GRID_W    = 160,
    parameter int GRID_H    = 120,
    parameter int INIT_X    = 80,
    parameter int INIT_Y    = 100,
    parameter int TICK_MAX  = 2000000,
    parameter int PIX_SHIFT = 2,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          ENABLE,
    input  logic [1:0]    DIR_IN,
    input  logic          GROW,
    input  logic [9:0]    X_ADDR,
    input  logic [8:0]    Y_ADDR,
    output logic [7:0]    HEAD_X,
    output logic [6:0]    HEAD_Y,
    output logic [LW-1:0] LENGTH,
    output logic          STEP,
    output logic          COLLIDE,
    output logic          FULL,
    output logic          PIX_HEAD,
    output logic          PIX_BODY
);
    localparam int CW = $clog2(TICK_MAX + 1);
    localparam logic [CW-1:0] TLAST = CW'(TICK_MAX - 1);
    localparam logic [7:0]    XMAX  = 8'(GRID_W - 1);
    localparam logic [6:0]    YMAX  = 7'(GRID_H - 1);
    localparam logic [7:0]    X0    = 8'(INIT_X);
    localparam logic [6:0]    Y0    = 7'(INIT_Y);
    localparam logic [LW-1:0] L0    = LW'(INIT_LEN);
    localparam logic [LW-1:0] LMAX  = LW'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    seg_x [MAX_LEN];
    logic [6:0]    seg_y [MAX_LEN];
    logic [LW-1:0] len;
    logic [1:0]    cur, pend, dir;
    logic [CW-1:0] cnt;
    logic          grow_pend, grow, growing, step, coll, hit;
    logic [7:0]    nx;
    logic [6:0]    ny;
    logic [9:0]    cx;
    logic [8:0]    cy;
    logic          ph, pb;

    assign step    = state_q == RUN && cnt == TLAST;
    // A reversal request leaves the previously accepted pending direction in place
    assign dir     = (state_q == RUN && DIR_IN != (cur ^ 2'd2)) ? DIR_IN : pend;
    assign grow    = grow_pend | GROW;
    assign growing = grow && !FULL;
    assign hit     = step && coll;
    assign STEP    = step && !coll;
    assign FULL    = len == LMAX;
    assign LENGTH  = len;
    assign HEAD_X  = seg_x[0];
    assign HEAD_Y  = seg_y[0];
    assign cx      = X_ADDR >> PIX_SHIFT;
    assign cy      = Y_ADDR >> PIX_SHIFT;

    always_comb begin
        nx = dir == 2'd1 ? (seg_x[0] == 8'd0 ? XMAX : seg_x[0] - 8'd1) :
             dir == 2'd3 ? (seg_x[0] == XMAX ? 8'd0 : seg_x[0] + 8'd1) : seg_x[0];
        ny = dir == 2'd0 ? (seg_y[0] == 7'd0 ? YMAX : seg_y[0] - 7'd1) :
             dir == 2'd2 ? (seg_y[0] == YMAX ? 7'd0 : seg_y[0] + 7'd1) : seg_y[0];
    end

    // The tail only counts as an obstacle when it stays put because of growth
    always_comb begin
        coll = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            if (seg_x[i] == nx && seg_y[i] == ny &&
                (i < int'(len) - 1 || (i == int'(len) - 1 && growing)))
                coll = 1'b1;
    end

    always_comb begin
        state_d = !ENABLE ? IDLE :
                  state_q == IDLE ? RUN :
                  (state_q == RUN && hit) ? DEAD : state_q;
    end

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) state_q <= IDLE;
        else state_q <= state_d;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X0;
                seg_y[i] <= Y0;
            end
            len       <= L0;
            cur       <= 2'd0;
            pend      <= 2'd0;
            cnt       <= '0;
            grow_pend <= 1'b0;
            COLLIDE   <= 1'b0;
        end else if (state_d == IDLE) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= X0;
                seg_y[i] <= Y0;
            end
            len       <= L0;
            cur       <= 2'd0;
            pend      <= 2'd0;
            cnt       <= '0;
            grow_pend <= 1'b0;
            COLLIDE   <= 1'b0;
        end else if (state_q == RUN) begin
            cnt       <= step ? '0 : cnt + 1'b1;
            pend      <= dir;
            grow_pend <= grow && !step;
            if (hit) begin
                COLLIDE <= 1'b1;
            end else if (step) begin
                cur <= dir;
                for (int i = MAX_LEN - 1; i > 0; i--) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nx;
                seg_y[0] <= ny;
                if (growing) len <= len + 1'b1;
            end
        end
    end

    always_comb begin
        ph = cx == {2'b00, seg_x[0]} && cy == {2'b00, seg_y[0]};
        pb = 1'b0;
        for (int i = 1; i < MAX_LEN; i++)
            if (i < int'(len) && cx == {2'b00, seg_x[i]} && cy == {2'b00, seg_y[i]})
                pb = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N)
        if (!RESET_N) begin
            PIX_HEAD <= 1'b0;
            PIX_BODY <= 1'b0;
        end else begin
            PIX_HEAD <= ph;
            PIX_BODY <= pb && !ph;
        end
endmodule
